// File: rtl/n25q_read_seq_pkg.sv
// Shared types and constants for the N25Q flash-read sequencer.
// TERM_* mirror the engine terminal map so this slice elaborates on its own.
package n25q_read_seq_pkg;

  localparam logic [15:0] TERM_N25Q_CTRL = 16'h0001;
  localparam logic [15:0] TERM_N25Q_DATA = 16'h0002;

  typedef enum logic [2:0] {StIdle, StSel, StCmd, StGap, StRd, StDsel} state_e;

  // Engine handshake phase: pulse, then see rdy fall, then see it rise again.
  typedef enum logic [1:0] {HsReady, HsWaitFall, HsWaitRise, HsDone} hs_e;

  function automatic logic [2:0] chunk_bytes(input logic [24:0] rem);
    return (rem >= 25'd4) ? 3'd4 : rem[2:0];
  endfunction

endpackage

// File: rtl/n25q_read_seq_obuf.sv
// One-entry output register for the word stream; holds data stable until ready.
module n25q_read_seq_obuf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  input  logic        last_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [2:0]  nbytes_o,
  output logic        last_o
);

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic        last_q, last_d;

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    nbytes_d = nbytes_q;
    last_d   = last_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    // A push on the same cycle as a pop simply replaces the entry.
    if (push_i) begin
      valid_d  = 1'b1;
      data_d   = data_i;
      nbytes_d = nbytes_i;
      last_d   = last_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      nbytes_q <= '0;
      last_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      nbytes_q <= nbytes_d;
      last_q   <= last_d;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign nbytes_o = nbytes_q;
  assign last_o   = last_q;

endmodule

// File: rtl/n25q_read_seq.sv
// Autonomous flash-read sequencer: selects the flash, sends READ + address through the
// SPI byte engine, streams the data back as 32-bit words, then deselects.
module n25q_read_seq
  import n25q_read_seq_pkg::*;
#(
  parameter logic [31:0] CTRL_CSB_ADDR = 32'h0,
  parameter logic [31:0] CSB_HIGH_VAL  = 32'h1,
  parameter logic [7:0]  OPCODE_READ   = 8'h03
) (
  input  logic        ifclk,
  input  logic        resetb,
  input  logic        start,
  input  logic [23:0] start_addr,
  input  logic [24:0] start_len,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [31:0] o_data,
  output logic [2:0]  o_nbytes,
  output logic        o_last,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [15:0] m_term_addr,
  output logic [31:0] m_reg_addr,
  output logic        m_write_mode,
  output logic        m_write,
  output logic        m_read_mode,
  output logic        m_read_req,
  output logic        m_read,
  output logic [31:0] m_len,
  output logic [31:0] m_reg_datai,
  input  logic        m_write_rdy,
  input  logic        m_read_rdy,
  input  logic [31:0] m_reg_datao
);

  state_e      state_q, state_d;
  hs_e         hs_q, hs_d;
  logic [23:0] addr_q, addr_d;
  logic [24:0] rem_q, rem_d;
  logic        abort_q, abort_d, cut_q, cut_d;
  logic        busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic [15:0] term_q, term_d;
  logic [31:0] reg_addr_q, reg_addr_d, len_q, len_d, datai_q, datai_d;
  logic        wmode_q, wmode_d, write_q, write_d, rmode_q, rmode_d, rreq_q, rreq_d;

  logic        push, push_last, abort_pend, go_dsel, wr_fire, wr_done, rdy_sel;
  logic [2:0]  push_nb;
  logic [24:0] rem_next;

  always_comb begin
    state_d = state_q;       hs_d = hs_q;           addr_d = addr_q;     rem_d = rem_q;
    abort_d = abort_q;       cut_d = cut_q;         busy_d = busy_q;     done_d = 1'b0;
    aborted_d = 1'b0;        term_d = term_q;       reg_addr_d = reg_addr_q;
    len_d = len_q;           datai_d = datai_q;     wmode_d = wmode_q;   rmode_d = rmode_q;
    write_d = 1'b0;          rreq_d = 1'b0;         push = 1'b0;         go_dsel = 1'b0;

    push_nb    = chunk_bytes(rem_q);
    rem_next   = rem_q - {22'd0, push_nb};
    abort_pend = abort_q | abort;
    push_last  = (rem_next == 25'd0) | abort_pend;
    rdy_sel    = (state_q == StRd) ? m_read_rdy : m_write_rdy;
    wr_fire    = (hs_q == HsReady) && m_write_rdy;
    wr_done    = (hs_q == HsWaitRise) && m_write_rdy;

    if (busy_q && abort) abort_d = 1'b1;
    if (hs_q == HsWaitFall && !rdy_sel) hs_d = HsWaitRise;

    unique case (state_q)
      StIdle: if (start) begin
        if (start_len == 25'd0) begin
          done_d = 1'b1;
        end else begin
          state_d = StSel;   addr_d = start_addr;   rem_d = start_len;   busy_d = 1'b1;
          abort_d = 1'b0;    cut_d = 1'b0;          hs_d = HsReady;
          term_d = TERM_N25Q_CTRL;  reg_addr_d = CTRL_CSB_ADDR;  datai_d = '0;
        end
      end
      StSel: begin
        if (wr_fire) begin write_d = 1'b1; hs_d = HsWaitFall; end
        if (wr_done) begin
          hs_d = HsReady;
          if (abort_pend) begin
            cut_d = 1'b1; go_dsel = 1'b1;
          end else begin
            state_d = StCmd;  term_d = TERM_N25Q_DATA;  reg_addr_d = '0;
            wmode_d = 1'b1;   len_d = 32'd4;
            datai_d = {addr_q[7:0], addr_q[15:8], addr_q[23:16], OPCODE_READ};
          end
        end
      end
      StCmd: begin
        if (wr_fire) begin write_d = 1'b1; hs_d = HsWaitFall; end
        if (wr_done) begin
          hs_d = HsReady;  state_d = StGap;  wmode_d = 1'b0;  datai_d = '0;  len_d = '0;
        end
      end
      // Both modes low for one cycle so the engine clears its byte counter.
      StGap: begin
        if (abort_pend) begin
          cut_d = 1'b1; go_dsel = 1'b1;
        end else begin
          state_d = StRd;  rmode_d = 1'b1;  len_d = {7'd0, rem_q};
        end
      end
      StRd: begin
        if (hs_q == HsReady && !o_valid && m_read_rdy) begin
          rreq_d = 1'b1; hs_d = HsWaitFall;
        end
        if (hs_q == HsWaitRise && m_read_rdy) begin
          push = 1'b1;  rem_d = rem_next;  len_d = {7'd0, rem_next};  hs_d = HsReady;
          if (push_last) begin
            rmode_d = 1'b0;  go_dsel = 1'b1;  cut_d = abort_pend && (rem_next != 25'd0);
          end
        end
      end
      StDsel: begin
        if (wr_fire) begin write_d = 1'b1; hs_d = HsWaitFall; end
        if (wr_done) hs_d = HsDone;
        if (hs_q == HsDone && !o_valid) begin
          state_d = StIdle;  hs_d = HsReady;  busy_d = 1'b0;  done_d = 1'b1;
          aborted_d = cut_q; term_d = TERM_N25Q_DATA;  reg_addr_d = '0;  datai_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_dsel) begin
      state_d = StDsel;  hs_d = HsReady;  term_d = TERM_N25Q_CTRL;  reg_addr_d = CTRL_CSB_ADDR;
      datai_d = CSB_HIGH_VAL;  wmode_d = 1'b0;  rmode_d = 1'b0;  len_d = '0;
    end
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q <= StIdle;  hs_q <= HsReady;  addr_q <= '0;  rem_q <= '0;
      abort_q <= 1'b0;    cut_q <= 1'b0;    busy_q <= 1'b0; done_q <= 1'b0;
      aborted_q <= 1'b0;  term_q <= TERM_N25Q_DATA;  reg_addr_q <= '0;  len_q <= '0;
      datai_q <= '0;      wmode_q <= 1'b0;  write_q <= 1'b0;  rmode_q <= 1'b0;  rreq_q <= 1'b0;
    end else begin
      state_q <= state_d;  hs_q <= hs_d;  addr_q <= addr_d;  rem_q <= rem_d;
      abort_q <= abort_d;  cut_q <= cut_d;  busy_q <= busy_d;  done_q <= done_d;
      aborted_q <= aborted_d;  term_q <= term_d;  reg_addr_q <= reg_addr_d;  len_q <= len_d;
      datai_q <= datai_d;  wmode_q <= wmode_d;  write_q <= write_d;  rmode_q <= rmode_d;
      rreq_q <= rreq_d;
    end
  end

  n25q_read_seq_obuf u_obuf (
    .clk_i    (ifclk),
    .rst_ni   (resetb),
    .push_i   (push),
    .data_i   (m_reg_datao),
    .nbytes_i (push_nb),
    .last_i   (push_last),
    .ready_i  (o_ready),
    .valid_o  (o_valid),
    .data_o   (o_data),
    .nbytes_o (o_nbytes),
    .last_o   (o_last)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign m_term_addr  = term_q;
  assign m_reg_addr   = reg_addr_q;
  assign m_write_mode = wmode_q;
  assign m_write      = write_q;
  assign m_read_mode  = rmode_q;
  assign m_read_req   = rreq_q;
  assign m_read       = 1'b0;
  assign m_len        = len_q;
  assign m_reg_datai  = datai_q;

endmodule

// File: tb/tb_n25q_read_seq.sv
// Bench for n25q_read_seq: a small engine/flash model answers the m_* port and a
// word-level model of the expected stream is compared on every handshake.
module tb_n25q_read_seq;
  import n25q_read_seq_pkg::*;

  logic        ifclk = 1'b0, resetb = 1'b0;
  logic        start, abort, o_ready;
  logic [23:0] start_addr;
  logic [24:0] start_len;
  logic        busy, done, aborted, o_last, o_valid;
  logic [31:0] o_data;
  logic [2:0]  o_nbytes;
  logic [15:0] m_term_addr;
  logic [31:0] m_reg_addr, m_len, m_reg_datai, m_reg_datao;
  logic        m_write_mode, m_write, m_read_mode, m_read_req, m_read;
  logic        m_write_rdy, m_read_rdy;

  n25q_read_seq dut (
    .ifclk(ifclk), .resetb(resetb), .start(start), .start_addr(start_addr),
    .start_len(start_len), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .o_data(o_data), .o_nbytes(o_nbytes), .o_last(o_last), .o_valid(o_valid),
    .o_ready(o_ready), .m_term_addr(m_term_addr), .m_reg_addr(m_reg_addr),
    .m_write_mode(m_write_mode), .m_write(m_write), .m_read_mode(m_read_mode),
    .m_read_req(m_read_req), .m_read(m_read), .m_len(m_len), .m_reg_datai(m_reg_datai),
    .m_write_rdy(m_write_rdy), .m_read_rdy(m_read_rdy), .m_reg_datao(m_reg_datao)
  );

  always #5 ifclk = ~ifclk;

  int checks = 0, errors = 0;

  typedef struct { logic [31:0] d; int n; bit last; } wexp_t;
  wexp_t       exp_q[$];
  logic [31:0] got_w[$];
  logic [7:0]  mosi_q[$];
  int          rd_len_log[$];
  int          wr_pulses = 0, rd_pulses = 0, exp_rem = 0, eng_cnt;
  logic [23:0] rd_ptr;
  logic        csb;

  function automatic logic [7:0] fbyte(input int a);
    logic [7:0] b;
    b = a[7:0];
    return b ^ 8'h5A;
  endfunction

  function automatic int rd_n(input logic [31:0] l);
    return (l > 32'd4) ? 4 : int'(l);
  endfunction

  function automatic logic [31:0] bmask(input int n);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < n; j++) m[8*j +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] eng_word(input logic [23:0] p, input logic [31:0] l);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < rd_n(l); j++) w[8*j +: 8] = fbyte(int'(p) + j);
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected word list from address/length alone, optionally cut after maxw words.
  task automatic plan(input int addr, input int len, input int maxw);
    int nw;
    nw = (len + 3) / 4;
    if (maxw < nw) nw = maxw;
    for (int i = 0; i < nw; i++) begin
      wexp_t w;
      int n;
      n = len - 4 * i;
      if (n > 4) n = 4;
      w.d = '0;
      for (int j = 0; j < n; j++) w.d[8*j +: 8] = fbyte(addr + 4 * i + j);
      w.n = n;
      w.last = (i == nw - 1);
      exp_q.push_back(w);
    end
    exp_rem = len;
  endtask

  // Engine + flash model: rdy drops for a few cycles after each pulse.
  always @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      m_write_rdy <= 1'b1; m_read_rdy <= 1'b1; eng_cnt <= 0;
      m_reg_datao <= '0;   rd_ptr <= '0;       csb <= 1'b1;
    end else begin
      if (eng_cnt == 1) begin m_write_rdy <= 1'b1; m_read_rdy <= 1'b1; end
      if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
      if (m_write) begin
        m_write_rdy <= 1'b0; m_read_rdy <= 1'b0; eng_cnt <= 3;
        if (m_term_addr == TERM_N25Q_CTRL && m_reg_addr == 32'h0) csb <= m_reg_datai[0];
        else if (m_write_mode && m_reg_datai[7:0] == 8'h03)
          rd_ptr <= {m_reg_datai[15:8], m_reg_datai[23:16], m_reg_datai[31:24]};
      end
      if (m_read_req) begin
        m_write_rdy <= 1'b0; m_read_rdy <= 1'b0; eng_cnt <= 4;
        m_reg_datao <= eng_word(rd_ptr, m_len);
        rd_ptr <= rd_ptr + 24'(rd_n(m_len));
      end
    end
  end

  logic        hold_prev = 1'b0, last_prev;
  logic [31:0] data_prev;
  logic [2:0]  nb_prev;

  // Compare process: bus protocol, read lengths and the output stream.
  always @(negedge ifclk) begin : mon
    wexp_t w;
    if (!resetb) begin
      hold_prev = 1'b0;
    end else begin
      if (m_write || m_read_req) begin
        chk("one_pulse", 32'(m_write & m_read_req), 32'd0);
        if (m_write) chk("wr_rdy", 32'(m_write_rdy), 32'd1);
        else chk("rd_rdy", 32'(m_read_rdy), 32'd1);
      end
      if (m_write) begin
        wr_pulses++;
        if (m_term_addr == TERM_N25Q_DATA && m_write_mode)
          for (int j = 0; j < rd_n(m_len); j++) mosi_q.push_back(m_reg_datai[8*j +: 8]);
      end
      if (m_read_req) begin
        chk("rd_len", m_len, 32'(exp_rem));
        exp_rem -= rd_n(m_len);
        rd_pulses++;
        rd_len_log.push_back(int'(m_len));
      end
      if (hold_prev && o_valid) begin
        chk("hold_data", o_data & bmask(int'(nb_prev)), data_prev & bmask(int'(nb_prev)));
        chk("hold_nbytes", 32'(o_nbytes), 32'(nb_prev));
        chk("hold_last", 32'(o_last), 32'(last_prev));
      end
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_extra: got word %0h expected none", o_data);
        end else begin
          w = exp_q.pop_front();
          chk("nbytes", 32'(o_nbytes), 32'(w.n));
          chk("data", o_data & bmask(w.n), w.d);
          chk("last", 32'(o_last), 32'(w.last));
          got_w.push_back(o_data);
        end
      end
      hold_prev = o_valid && !o_ready;
      data_prev = o_data; nb_prev = o_nbytes; last_prev = o_last;
    end
  end

  task automatic do_start(input logic [23:0] a, input logic [24:0] l);
    start_addr = a; start_len = l; start = 1'b1;
    @(posedge ifclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ab);
    bit ok;
    ok = 1'b0; ab = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      if (done) begin ok = 1'b1; ab = aborted; end
      else begin @(posedge ifclk); #1; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL done_timeout: got no done expected done"); end
  endtask

  task automatic wait_words(input int n, input int maxc);
    int i;
    for (i = 0; i < maxc && got_w.size() < n; i++) begin @(posedge ifclk); #1; end
    chk("words_timeout", 32'(got_w.size() >= n), 32'd1);
  endtask

  initial begin
    bit ab;
    int rp, wp;
    start = 1'b0; abort = 1'b0; o_ready = 1'b1; start_addr = '0; start_len = '0;
    repeat (3) @(posedge ifclk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_term", 32'(m_term_addr), 32'(TERM_N25Q_DATA));
    chk("rst_datai", m_reg_datai, 32'd0);
    chk("rst_pulses", 32'({m_write, m_read_req, m_read, m_write_mode, m_read_mode}), 32'd0);
    resetb = 1'b1;
    @(posedge ifclk); #1;

    // Basic 8-byte read
    plan(24'h123456, 8, 99);
    do_start(24'h123456, 25'd8);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done(2000, ab);
    chk("t1_aborted", 32'(ab), 32'd0);
    chk("t1_left", 32'(exp_q.size()), 32'd0);
    chk("t1_mosi_n", 32'(mosi_q.size()), 32'd4);
    if (mosi_q.size() == 4)
      chk("t1_mosi", {mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3]}, 32'h03123456);
    chk("t1_csb", 32'(csb), 32'd1);
    chk("t1_nwords", 32'(got_w.size()), 32'd2);
    if (got_w.size() == 2) begin
      chk("t1_w0", got_w[0], 32'h03020D0C);
      chk("t1_w1", got_w[1], 32'h07060100);
    end

    // 5 bytes: words of 4 then 1
    rd_len_log.delete();
    plan(24'h000100, 5, 99);
    do_start(24'h000100, 25'd5);
    wait_done(2000, ab);
    chk("t2_left", 32'(exp_q.size()), 32'd0);
    chk("t2_nreads", 32'(rd_len_log.size()), 32'd2);
    if (rd_len_log.size() == 2) chk("t2_len2", 32'(rd_len_log[1]), 32'd1);

    // Zero length
    wp = wr_pulses;
    do_start(24'h000010, 25'd0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    @(posedge ifclk); #1;
    chk("t3_done_off", 32'(done), 32'd0);
    chk("t3_nowrite", 32'(wr_pulses - wp), 32'd0);

    // Back-pressure: first word held for 200 cycles
    plan(24'h0000F0, 8, 99);
    o_ready = 1'b0;
    do_start(24'h0000F0, 25'd8);
    for (int i = 0; i < 200 && !o_valid; i++) begin @(posedge ifclk); #1; end
    chk("t4_valid", 32'(o_valid), 32'd1);
    rp = rd_pulses;
    repeat (200) @(posedge ifclk);
    #1;
    chk("t4_noread", 32'(rd_pulses - rp), 32'd0);
    chk("t4_still", 32'(o_valid), 32'd1);
    o_ready = 1'b1;
    wait_done(2000, ab);
    chk("t4_left", 32'(exp_q.size()), 32'd0);

    // Abort after word 2 accepted: word 3 is last
    got_w.delete();
    plan(24'h001000, 64, 3);
    do_start(24'h001000, 25'd64);
    wait_words(2, 2000);
    abort = 1'b1;
    wait_done(2000, ab);
    abort = 1'b0;
    chk("t5_aborted", 32'(ab), 32'd1);
    chk("t5_nwords", 32'(got_w.size()), 32'd3);
    chk("t5_left", 32'(exp_q.size()), 32'd0);
    chk("t5_csb", 32'(csb), 32'd1);

    // Asynchronous reset while reading, then a fresh read
    got_w.delete();
    plan(24'h002000, 64, 99);
    do_start(24'h002000, 25'd64);
    wait_words(1, 2000);
    #2;
    resetb = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_rmode", 32'(m_read_mode), 32'd0);
    chk("t6_term", 32'(m_term_addr), 32'(TERM_N25Q_DATA));
    chk("t6_len", m_len, 32'd0);
    exp_q.delete();
    got_w.delete();
    @(posedge ifclk); #1;
    resetb = 1'b1;
    @(posedge ifclk); #1;
    plan(24'h123456, 5, 99);
    do_start(24'h123456, 25'd5);
    wait_done(2000, ab);
    chk("t6_left", 32'(exp_q.size()), 32'd0);
    if (got_w.size() > 0) chk("t6_w0", got_w[0], 32'h03020D0C);
    else chk("t6_nwords", 32'(got_w.size()), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
